cpu_ctrl_fsm: RTL and testbench
===============================

# cpu_ctrl_fsm

Multicycle control unit for the 16-bit CPU. It accepts one instruction per handshake, latches it into an instruction register, and steps a registered 4-bit state machine through the execute sequence. In each state it drives the bus-based datapath: register file in/out enables, A/G accumulator strobes, ALU opcode, and PC control. It sits between the instruction source and the datapath and replaces the free-standing next-state decode with a complete sequencer.

## Interface
- NREGS, 8, number of general registers (one-hot enable width); rx/ry fields are 3 bits
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- new_instr  in  1  instruction valid; sampled only in IDLE
- instr  in  16  instruction: [15:13] opcode, [12:10] rx, [9:7] ry
- z_flag  in  1  ALU zero flag (used only with CTRL_BRANCH_ZERO_EN)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in the final execute state
- illegal  out  1  one-cycle pulse in DECODE when opcode = 111
- state  out  4  current state code (debug)
- rin  out  NREGS  one-hot register write enable
- rout  out  NREGS  one-hot register bus drive
- din_out, pc_out, gout  out  1 each  bus drive for immediate data, PC, G
- ain, gin  out  1 each  load A, load G
- alu_op  out  2  00 ADD, 01 SUB, 10 XOR
- pc_inc, pc_in  out  1 each  increment PC; load PC from bus

## Operation
- State codes: IDLE 0000, DECODE 0001, LOAD 0010, MOV 0011, LDPC 0100, BRANCH 0101, SUB0-2 0110-1000, ADD0-2 1001-1011, XOR0-2 1100-1110; 1111 goes to IDLE.
- IDLE: when new_instr=1, IR <= instr and go to DECODE; otherwise stay. new_instr is ignored in every other state.
- DECODE: pulse pc_inc and dispatch on IR[15:13]: 000 LOAD, 001 MOV, 010 ADD0, 011 SUB0, 100 XOR0, 101 LDPC, 110 BRANCH, 111 IDLE with illegal=1.
- LOAD: din_out, rin[rx], done. MOV: rout[ry], rin[rx], done. LDPC: pc_out, rin[rx], done. BRANCH: rout[rx], pc_in, done.
- xx0: rout[rx], ain. xx1: rout[ry], gin, alu_op per op. xx2: gout, rin[rx], done.
- Single-cycle ops (LOAD, MOV, LDPC, BRANCH) and xx2 return to IDLE.
- Outputs are a Moore decode of state and IR; all strobes not listed for a state are 0, and alu_op is 00 outside xx1.
- rx = ry is legal. MOV rx,rx asserts rout and rin on the same index.

## Timing
- Reset (async assert, release on clk edge): state=IDLE, IR=0. All outputs are 0, including rin=rout=0.
- Acceptance edge is T0. DECODE is in cycle T0+1. Single-cycle ops execute in T0+2 with done, and IDLE is back at T0+3.
- ALU ops: xx0 at T0+2, xx1 at T0+3, xx2 with done at T0+4, IDLE at T0+5.
- A new instruction can be accepted on the first IDLE cycle after done (back-to-back throughput: 3 or 5 cycles).
- Reset mid-sequence aborts immediately: no further strobes, no done.
- instr may change freely after acceptance; execution uses IR only.

## Configuration
- CTRL_BRANCH_ZERO_EN defined: BRANCH drives pc_in only if z_flag=1 in the BRANCH cycle. done still pulses.
- CTRL_BRANCH_ZERO_EN undefined: branch is unconditional and z_flag is unused.

## Structure
- Package cpu_ctrl_pkg holds:
  - the state enum with the fixed 4-bit codes above;
  - opcode constants OP_LOAD..OP_BRANCH and OP_ILLEGAL (3'b111);
  - ALU op constants.
- Sub-module dec3to8 converts a 3-bit field to an 8-bit one-hot with enable, used for rin and rout.

## Test plan
- Reset then idle: rst_n low mid-ADD1 -> next cycle state=0000, all outputs 0, no done.
- ADD r2,r5 (instr=16'h4A80) with new_instr=1 -> state sequence 0001,1001,1010,1011,0000. Strobes:
  - ADD0: rout=8'h04, ain=1.
  - ADD1: rout=8'h20, gin=1, alu_op=00.
  - ADD2: gout=1, rin=8'h04, done=1.
- MOV r1,r3 (16'h2580) -> MOV cycle: rout=8'h08, rin=8'h02, done=1. pc_inc=1 only in DECODE.
- Illegal opcode (16'hE000) -> DECODE with illegal=1, then IDLE, with no rin/rout and no done. new_instr held high during ADD execution is ignored until IDLE.
- BRANCH r4 (16'hD000) with z_flag=0:
  - with CTRL_BRANCH_ZERO_EN: pc_in=0, done=1;
  - without it: rout=8'h10, pc_in=1.

Source files
------------

// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared types for the multicycle CPU control unit: state codes, opcodes, ALU ops.
// Pure declarations; no timing or flow-control behaviour of its own.
package cpu_ctrl_pkg;

  localparam int NREGS = 8;

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0000,
    S_DECODE = 4'b0001,
    S_LOAD   = 4'b0010,
    S_MOV    = 4'b0011,
    S_LDPC   = 4'b0100,
    S_BRANCH = 4'b0101,
    S_SUB0   = 4'b0110,
    S_SUB1   = 4'b0111,
    S_SUB2   = 4'b1000,
    S_ADD0   = 4'b1001,
    S_ADD1   = 4'b1010,
    S_ADD2   = 4'b1011,
    S_XOR0   = 4'b1100,
    S_XOR1   = 4'b1101,
    S_XOR2   = 4'b1110,
    S_RSVD   = 4'b1111
  } state_t;

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_MOV     = 3'b001;
  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_XOR     = 3'b100;
  localparam logic [2:0] OP_LDPC    = 3'b101;
  localparam logic [2:0] OP_BRANCH  = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Instruction handshake plus datapath control strobes between the sequencer and its neighbours.
// slave = control unit; master = instruction source / datapath side.
interface cpu_ctrl_fsm_if;
  import cpu_ctrl_pkg::*;

  logic             new_instr;
  logic [15:0]      instr;
  logic             z_flag;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [3:0]       state;
  logic [NREGS-1:0] rin;
  logic [NREGS-1:0] rout;
  logic             din_out;
  logic             pc_out;
  logic             gout;
  logic             ain;
  logic             gin;
  logic [1:0]       alu_op;
  logic             pc_inc;
  logic             pc_in;

  modport slave (
    input  new_instr, instr, z_flag,
    output busy, done, illegal, state, rin, rout, din_out, pc_out, gout,
           ain, gin, alu_op, pc_inc, pc_in
  );

  modport master (
    output new_instr, instr, z_flag,
    input  busy, done, illegal, state, rin, rout, din_out, pc_out, gout,
           ain, gin, alu_op, pc_inc, pc_in
  );
endinterface

// File: rtl/cpu_ctrl_fsm_dec3to8.sv
// 3-bit field to 8-bit one-hot with enable; purely combinational, no backpressure.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] onehot
);
  assign onehot = en ? (8'b0000_0001 << sel) : 8'b0;
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle sequencer: latches one instruction in IDLE, then 3 (single-cycle op) or 5 (ALU op) cycles
// back to IDLE; new_instr is ignored while busy. Define CTRL_BRANCH_ZERO_EN to make BRANCH conditional on z_flag.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  cpu_ctrl_fsm_if.slave  bus
);

  state_t      state_q, state_d;
  logic [8:0]  ir_q;              // opcode, rx, ry; the low instruction bits never steer control
  logic [2:0]  opcode, rx, ry;
  logic        rin_en, rout_en;
  logic [2:0]  rout_sel;

  assign opcode = ir_q[8:6];
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.new_instr)
        ir_q <= bus.instr[15:7];
    end
  end

  always_comb begin
    state_d     = state_q;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    rout_sel    = rx;
    bus.done    = 1'b0;
    bus.illegal = 1'b0;
    bus.din_out = 1'b0;
    bus.pc_out  = 1'b0;
    bus.gout    = 1'b0;
    bus.ain     = 1'b0;
    bus.gin     = 1'b0;
    bus.alu_op  = ALU_ADD;
    bus.pc_inc  = 1'b0;
    bus.pc_in   = 1'b0;

    case (state_q)
      S_IDLE: if (bus.new_instr) state_d = S_DECODE;
      S_DECODE: begin
        bus.pc_inc = 1'b1;
        case (opcode)
          OP_LOAD:   state_d = S_LOAD;
          OP_MOV:    state_d = S_MOV;
          OP_ADD:    state_d = S_ADD0;
          OP_SUB:    state_d = S_SUB0;
          OP_XOR:    state_d = S_XOR0;
          OP_LDPC:   state_d = S_LDPC;
          OP_BRANCH: state_d = S_BRANCH;
          default: begin
            bus.illegal = 1'b1;
            state_d     = S_IDLE;
          end
        endcase
      end
      S_LOAD: begin
        bus.din_out = 1'b1;
        rin_en      = 1'b1;
        bus.done    = 1'b1;
        state_d     = S_IDLE;
      end
      S_MOV: begin
        rout_en  = 1'b1;
        rout_sel = ry;
        rin_en   = 1'b1;
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      S_LDPC: begin
        bus.pc_out = 1'b1;
        rin_en     = 1'b1;
        bus.done   = 1'b1;
        state_d    = S_IDLE;
      end
      S_BRANCH: begin
        rout_en = 1'b1;
`ifdef CTRL_BRANCH_ZERO_EN
        bus.pc_in = bus.z_flag;
`else
        bus.pc_in = 1'b1;
`endif
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      S_ADD0, S_SUB0, S_XOR0: begin
        rout_en = 1'b1;
        bus.ain = 1'b1;
        state_d = state_t'(state_q + 4'd1);
      end
      S_ADD1, S_SUB1, S_XOR1: begin
        rout_en  = 1'b1;
        rout_sel = ry;
        bus.gin  = 1'b1;
        bus.alu_op = (state_q == S_SUB1) ? ALU_SUB :
                     (state_q == S_XOR1) ? ALU_XOR : ALU_ADD;
        state_d  = state_t'(state_q + 4'd1);
      end
      S_ADD2, S_SUB2, S_XOR2: begin
        bus.gout = 1'b1;
        rin_en   = 1'b1;
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.state = state_q;

  dec3to8 u_rin_dec (
    .en     (rin_en),
    .sel    (rx),
    .onehot (bus.rin)
  );

  dec3to8 u_rout_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (bus.rout)
  );

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed plus random instruction streams checked cycle-by-cycle against a per-opcode behavioural model.
module tb_cpu_ctrl_fsm;
  import cpu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_ctrl_fsm_if bus ();

  cpu_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] state;
    logic       busy;
    logic       done;
    logic       illegal;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       din_out;
    logic       pc_out;
    logic       gout;
    logic       ain;
    logic       gin;
    logic [1:0] alu_op;
    logic       pc_inc;
    logic       pc_in;
  } obs_t;

  function automatic obs_t observe();
    obs_t o;
    o.state   = bus.state;
    o.busy    = bus.busy;
    o.done    = bus.done;
    o.illegal = bus.illegal;
    o.rin     = bus.rin;
    o.rout    = bus.rout;
    o.din_out = bus.din_out;
    o.pc_out  = bus.pc_out;
    o.gout    = bus.gout;
    o.ain     = bus.ain;
    o.gin     = bus.gin;
    o.alu_op  = bus.alu_op;
    o.pc_inc  = bus.pc_inc;
    o.pc_in   = bus.pc_in;
    return o;
  endfunction

  // Number of busy cycles an instruction occupies (DECODE included).
  function automatic int ncyc(input logic [15:0] iv);
    int op;
    op = int'(iv[15:13]);
    if (op == 7) return 1;
    if (op == 2 || op == 3 || op == 4) return 4;
    return 2;
  endfunction

  // Expected outputs in busy cycle k after acceptance (k=0 is DECODE).
  function automatic obs_t model(input logic [15:0] iv, input int k, input logic z);
    obs_t e;
    int op, rx, ry, base;
    e  = '0;
    op = int'(iv[15:13]);
    rx = int'(iv[12:10]);
    ry = int'(iv[9:7]);
    e.busy = 1'b1;
    if (k == 0) begin
      e.state   = 4'd1;
      e.pc_inc  = 1'b1;
      e.illegal = (op == 7);
      return e;
    end
    case (op)
      0: begin e.state = 4'd2; e.din_out = 1'b1; e.rin = 8'(1 << rx); e.done = 1'b1; end
      1: begin e.state = 4'd3; e.rout = 8'(1 << ry); e.rin = 8'(1 << rx); e.done = 1'b1; end
      5: begin e.state = 4'd4; e.pc_out = 1'b1; e.rin = 8'(1 << rx); e.done = 1'b1; end
      6: begin
        e.state = 4'd5;
        e.rout  = 8'(1 << rx);
`ifdef CTRL_BRANCH_ZERO_EN
        e.pc_in = z;
`else
        e.pc_in = 1'b1;
`endif
        e.done  = 1'b1;
      end
      default: begin
        base    = (op == 2) ? 9 : (op == 3) ? 6 : 12;
        e.state = 4'(base + k - 1);
        if (k == 1) begin
          e.rout = 8'(1 << rx);
          e.ain  = 1'b1;
        end else if (k == 2) begin
          e.rout   = 8'(1 << ry);
          e.gin    = 1'b1;
          e.alu_op = (op == 2) ? 2'd0 : (op == 3) ? 2'd1 : 2'd2;
        end else begin
          e.gout = 1'b1;
          e.rin  = 8'(1 << rx);
          e.done = 1'b1;
        end
      end
    endcase
    if (z === 1'bx) e.pc_in = 1'bx;
    return e;
  endfunction

  task automatic check(input string tag, input obs_t exp);
    obs_t act;
    act = observe();
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %h (state %h) expected %h (state %h)",
             tag, act, act.state, exp, exp.state);
    end
  endtask

  // Called at a negedge in IDLE; ends at a negedge back in IDLE with new_instr low.
  task automatic exec(input logic [15:0] iv, input bit hold, input bit rand_z, input int abort_at);
    int n;
    n = ncyc(iv);
    bus.new_instr = 1'b1;
    bus.instr     = iv;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check($sformatf("instr_%h_step%0d", iv, k), model(iv, k, bus.z_flag));
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("reset_async", '0);
        @(negedge clk);
        check("reset_hold", '0);
        rst_n = 1'b1;
        bus.new_instr = 1'b0;
        @(negedge clk);
        check("reset_release_idle", '0);
        return;
      end
      bus.new_instr = hold ? 1'b1 : 1'($urandom);
      bus.instr     = 16'($urandom);
      if (rand_z) bus.z_flag = 1'($urandom);
    end
    @(negedge clk);
    check($sformatf("instr_%h_idle", iv), '0);
    bus.new_instr = 1'b0;
  endtask

  initial begin
    int gap;
    bus.new_instr = 1'b0;
    bus.instr     = 16'h0;
    bus.z_flag    = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_state", '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", '0);

    exec(16'h4A80, 1'b0, 1'b1, -1);  // ADD r2,r5
    exec(16'h2580, 1'b0, 1'b1, -1);  // MOV r1,r3
    exec(16'hE000, 1'b0, 1'b1, -1);  // illegal opcode
    exec(16'h4A80, 1'b1, 1'b1, -1);  // ADD with new_instr held high
    exec(16'h2480, 1'b0, 1'b1, -1);  // MOV r1,r1
    bus.z_flag = 1'b0;
    exec(16'hD000, 1'b0, 1'b0, -1);  // BRANCH r4, z=0
    bus.z_flag = 1'b1;
    exec(16'hD000, 1'b0, 1'b0, -1);  // BRANCH r4, z=1
    exec(16'h4A80, 1'b0, 1'b1, 2);   // reset during ADD1

    for (int i = 0; i < 60; i++) begin
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        @(negedge clk);
        check("idle_gap", '0);
      end
      exec(16'($urandom), 1'($urandom), 1'b1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
